// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decode-stage fields for EX with stall hold and flush bubble.
// Optional EX valid tracking is enabled by defining ID_EX_VALID_EN.
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned IMM_W      = 8,
  parameter int unsigned OPC_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,

  input  logic [OPC_W-1:0]      ID_opcode,
  input  logic                  ID_regwrite,
  input  logic                  ID_memtoreg,
  input  logic                  ID_memread,
  input  logic                  ID_memwrite,
  input  logic                  ID_alusrc,
  input  logic                  ID_aluop,
  input  logic                  ID_regdist,
  input  logic [IMM_W-1:0]      ID_immediate,
  input  logic [REG_ADDR_W-1:0] ID_rs,
  input  logic [REG_ADDR_W-1:0] ID_rt,
  input  logic [REG_ADDR_W-1:0] ID_rd,
  input  logic [DATA_W-1:0]     ID_rd1,
  input  logic [DATA_W-1:0]     ID_rd2,

  output logic [OPC_W-1:0]      EX_opcode,
  output logic                  EX_regwrite,
  output logic                  EX_memtoreg,
  output logic                  EX_memread,
  output logic                  EX_memwrite,
  output logic                  EX_alusrc,
  output logic                  EX_aluop,
  output logic                  EX_regdist,
  output logic [IMM_W-1:0]      EX_immediate,
  output logic [REG_ADDR_W-1:0] EX_rs,
  output logic [REG_ADDR_W-1:0] EX_rt,
  output logic [REG_ADDR_W-1:0] EX_rd,
  output logic [DATA_W-1:0]     EX_rd1,
  output logic [DATA_W-1:0]     EX_rd2
`ifdef ID_EX_VALID_EN
  ,
  input  logic                  ID_valid,
  output logic                  EX_valid
`endif
);

  logic [OPC_W-1:0]      opcode_d, opcode_q;
  logic                  regwrite_d, regwrite_q;
  logic                  memtoreg_d, memtoreg_q;
  logic                  memread_d, memread_q;
  logic                  memwrite_d, memwrite_q;
  logic                  alusrc_d, alusrc_q;
  logic                  aluop_d, aluop_q;
  logic                  regdist_d, regdist_q;
  logic [IMM_W-1:0]      immediate_d, immediate_q;
  logic [REG_ADDR_W-1:0] rs_d, rs_q;
  logic [REG_ADDR_W-1:0] rt_d, rt_q;
  logic [REG_ADDR_W-1:0] rd_d, rd_q;
  logic [DATA_W-1:0]     rd1_d, rd1_q;
  logic [DATA_W-1:0]     rd2_d, rd2_q;

  // Flush beats stall so a squashed instruction can never linger in EX.
  always_comb begin
    opcode_d    = opcode_q;
    regwrite_d  = regwrite_q;
    memtoreg_d  = memtoreg_q;
    memread_d   = memread_q;
    memwrite_d  = memwrite_q;
    alusrc_d    = alusrc_q;
    aluop_d     = aluop_q;
    regdist_d   = regdist_q;
    immediate_d = immediate_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    rd1_d       = rd1_q;
    rd2_d       = rd2_q;
    if (flush) begin
      opcode_d    = '0;
      regwrite_d  = 1'b0;
      memtoreg_d  = 1'b0;
      memread_d   = 1'b0;
      memwrite_d  = 1'b0;
      alusrc_d    = 1'b0;
      aluop_d     = 1'b0;
      regdist_d   = 1'b0;
      immediate_d = '0;
      rs_d        = '0;
      rt_d        = '0;
      rd_d        = '0;
      rd1_d       = '0;
      rd2_d       = '0;
    end else if (!stall) begin
      opcode_d    = ID_opcode;
      regwrite_d  = ID_regwrite;
      memtoreg_d  = ID_memtoreg;
      memread_d   = ID_memread;
      memwrite_d  = ID_memwrite;
      alusrc_d    = ID_alusrc;
      aluop_d     = ID_aluop;
      regdist_d   = ID_regdist;
      immediate_d = ID_immediate;
      rs_d        = ID_rs;
      rt_d        = ID_rt;
      rd_d        = ID_rd;
      rd1_d       = ID_rd1;
      rd2_d       = ID_rd2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opcode_q    <= '0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
      alusrc_q    <= 1'b0;
      aluop_q     <= 1'b0;
      regdist_q   <= 1'b0;
      immediate_q <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
    end else begin
      opcode_q    <= opcode_d;
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
      memread_q   <= memread_d;
      memwrite_q  <= memwrite_d;
      alusrc_q    <= alusrc_d;
      aluop_q     <= aluop_d;
      regdist_q   <= regdist_d;
      immediate_q <= immediate_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
    end
  end

  assign EX_opcode    = opcode_q;
  assign EX_regwrite  = regwrite_q;
  assign EX_memtoreg  = memtoreg_q;
  assign EX_memread   = memread_q;
  assign EX_memwrite  = memwrite_q;
  assign EX_alusrc    = alusrc_q;
  assign EX_aluop     = aluop_q;
  assign EX_regdist   = regdist_q;
  assign EX_immediate = immediate_q;
  assign EX_rs        = rs_q;
  assign EX_rt        = rt_q;
  assign EX_rd        = rd_q;
  assign EX_rd1       = rd1_q;
  assign EX_rd2       = rd2_q;

`ifdef ID_EX_VALID_EN
  logic valid_d, valid_q;

  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d = ID_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign EX_valid = valid_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: expected EX contents are queued as stimulus is driven.
module tb_id_ex_pipe_reg;

`ifdef ID_EX_VALID_EN
  localparam bit ValidEn = 1'b1;
`else
  localparam bit ValidEn = 1'b0;
`endif

  // ctl order: {regwrite, memtoreg, memread, memwrite, alusrc, aluop, regdist}
  typedef struct packed {
    logic [5:0]  opc;
    logic [6:0]  ctl;
    logic [7:0]  imm;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        valid;
  } fields_t;

  logic clk = 1'b0;
  logic rst_n, stall, flush;
  logic [5:0]  ID_opcode, EX_opcode;
  logic        ID_regwrite, ID_memtoreg, ID_memread, ID_memwrite, ID_alusrc, ID_aluop, ID_regdist;
  logic        EX_regwrite, EX_memtoreg, EX_memread, EX_memwrite, EX_alusrc, EX_aluop, EX_regdist;
  logic [7:0]  ID_immediate, EX_immediate;
  logic [2:0]  ID_rs, ID_rt, ID_rd, EX_rs, EX_rt, EX_rd;
  logic [31:0] ID_rd1, ID_rd2, EX_rd1, EX_rd2;
  logic        ID_valid, EX_valid;

  fields_t sb[$];
  fields_t exp_f, obs_f, fa, fb, fz;
  int n_checks = 0;
  int n_fail = 0;

  id_ex_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .ID_opcode(ID_opcode), .ID_regwrite(ID_regwrite), .ID_memtoreg(ID_memtoreg),
    .ID_memread(ID_memread), .ID_memwrite(ID_memwrite), .ID_alusrc(ID_alusrc),
    .ID_aluop(ID_aluop), .ID_regdist(ID_regdist), .ID_immediate(ID_immediate),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd), .ID_rd1(ID_rd1), .ID_rd2(ID_rd2),
    .EX_opcode(EX_opcode), .EX_regwrite(EX_regwrite), .EX_memtoreg(EX_memtoreg),
    .EX_memread(EX_memread), .EX_memwrite(EX_memwrite), .EX_alusrc(EX_alusrc),
    .EX_aluop(EX_aluop), .EX_regdist(EX_regdist), .EX_immediate(EX_immediate),
    .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_rd(EX_rd), .EX_rd1(EX_rd1), .EX_rd2(EX_rd2)
`ifdef ID_EX_VALID_EN
    ,
    .ID_valid(ID_valid), .EX_valid(EX_valid)
`endif
  );

`ifndef ID_EX_VALID_EN
  assign EX_valid = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic fields_t mk(input logic [5:0] opc, input logic [6:0] ctl,
                                 input logic [7:0] imm, input logic [2:0] rs,
                                 input logic [2:0] rt, input logic [2:0] rd,
                                 input logic [31:0] rd1, input logic [31:0] rd2,
                                 input logic v);
    fields_t f;
    f.opc = opc; f.ctl = ctl; f.imm = imm; f.rs = rs; f.rt = rt; f.rd = rd;
    f.rd1 = rd1; f.rd2 = rd2; f.valid = v & ValidEn;
    return f;
  endfunction

  function automatic fields_t observe();
    fields_t f;
    f.opc = EX_opcode;
    f.ctl = {EX_regwrite, EX_memtoreg, EX_memread, EX_memwrite, EX_alusrc, EX_aluop, EX_regdist};
    f.imm = EX_immediate; f.rs = EX_rs; f.rt = EX_rt; f.rd = EX_rd;
    f.rd1 = EX_rd1; f.rd2 = EX_rd2; f.valid = EX_valid;
    return f;
  endfunction

  task automatic drive(input fields_t f);
    ID_opcode = f.opc;
    {ID_regwrite, ID_memtoreg, ID_memread, ID_memwrite, ID_alusrc, ID_aluop, ID_regdist} = f.ctl;
    ID_immediate = f.imm; ID_rs = f.rs; ID_rt = f.rt; ID_rd = f.rd;
    ID_rd1 = f.rd1; ID_rd2 = f.rd2; ID_valid = f.valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(mk(6'h3f, 7'h7f, 8'hff, 3'h7, 3'h7, 3'h7, 32'hdeadbeef, 32'hcafef00d, 1'b1));
    for (int i = 0; i < 2; i++) begin
      sb.push_back(fz);
      @(posedge clk); #1;
      exp_f = sb.pop_front(); obs_f = observe(); n_checks++;
      if (obs_f !== exp_f) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %h want %h", i, obs_f, exp_f);
      end
    end
  endtask

  task automatic test_basic_load();
    rst_n = 1'b1;
    drive(fa); sb.push_back(fa);
    @(posedge clk); #1;
    exp_f = sb.pop_front(); obs_f = observe(); n_checks++;
    if (obs_f !== exp_f) begin
      n_fail++;
      $display("FAIL basic_load: got %h want %h", obs_f, exp_f);
    end
  endtask

  task automatic test_back_to_back();
    drive(fb); sb.push_back(fb);
    @(posedge clk); #1;
    exp_f = sb.pop_front(); obs_f = observe(); n_checks++;
    if (obs_f !== exp_f) begin
      n_fail++;
      $display("FAIL back_to_back: got %h want %h", obs_f, exp_f);
    end
    // Changing inputs between edges must not reach EX.
    drive(fa); #3;
    obs_f = observe(); n_checks++;
    if (obs_f !== fb) begin
      n_fail++;
      $display("FAIL between_edges: got %h want %h", obs_f, fb);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1; drive(fa);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(fb);
      @(posedge clk); #1;
      exp_f = sb.pop_front(); obs_f = observe(); n_checks++;
      if (obs_f !== exp_f) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got %h want %h", i, obs_f, exp_f);
      end
    end
    stall = 1'b0; sb.push_back(fa);
    @(posedge clk); #1;
    exp_f = sb.pop_front(); obs_f = observe(); n_checks++;
    if (obs_f !== exp_f) begin
      n_fail++;
      $display("FAIL stall_release: got %h want %h", obs_f, exp_f);
    end
  endtask

  task automatic test_flush();
    drive(fb); sb.push_back(fb);
    @(posedge clk); #1;
    exp_f = sb.pop_front(); obs_f = observe(); n_checks++;
    if (obs_f !== exp_f) begin
      n_fail++;
      $display("FAIL flush_preload: got %h want %h", obs_f, exp_f);
    end
    flush = 1'b1; stall = 1'b1; drive(fa); sb.push_back(fz);
    @(posedge clk); #1;
    exp_f = sb.pop_front(); obs_f = observe(); n_checks++;
    if (obs_f !== exp_f) begin
      n_fail++;
      $display("FAIL flush_over_stall: got %h want %h", obs_f, exp_f);
    end
    flush = 1'b0; stall = 1'b0; sb.push_back(fa);
    @(posedge clk); #1;
    exp_f = sb.pop_front(); obs_f = observe(); n_checks++;
    if (obs_f !== exp_f) begin
      n_fail++;
      $display("FAIL flush_resume: got %h want %h", obs_f, exp_f);
    end
  endtask

  task automatic test_reset_mid();
    drive(fb); sb.push_back(fb);
    @(posedge clk); #1;
    exp_f = sb.pop_front(); obs_f = observe(); n_checks++;
    if (obs_f !== exp_f) begin
      n_fail++;
      $display("FAIL valid_load: got %h want %h", obs_f, exp_f);
    end
    rst_n = 1'b0; stall = 1'b1; flush = 1'b0; sb.push_back(fz);
    @(posedge clk); #1;
    exp_f = sb.pop_front(); obs_f = observe(); n_checks++;
    if (obs_f !== exp_f) begin
      n_fail++;
      $display("FAIL reset_mid: got %h want %h", obs_f, exp_f);
    end
    rst_n = 1'b1; stall = 1'b0; drive(fa); sb.push_back(fa);
    @(posedge clk); #1;
    exp_f = sb.pop_front(); obs_f = observe(); n_checks++;
    if (obs_f !== exp_f) begin
      n_fail++;
      $display("FAIL reset_resume: got %h want %h", obs_f, exp_f);
    end
  endtask

  initial begin
    fz = mk(6'd0, 7'h00, 8'd0, 3'd0, 3'd0, 3'd0, 32'd0, 32'd0, 1'b0);
    fa = mk(6'd2, 7'h00, 8'd6, 3'd4, 3'd5, 3'd6, 32'd42, 32'd43, 1'b1);
    fb = mk(6'd8, 7'h7f, 8'd4, 3'd7, 3'd3, 3'd1, 32'd22, 32'd63, 1'b1);
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(fz);
    test_reset();
    test_basic_load();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
